// File: rtl/mem_arbiter_32_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_32_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // Latency countdown width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_32_rr.sv
// Two-way round-robin grant: ties go to the requester that did not win last.
module rr_arbiter_2
  import mem_arbiter_32_pkg::*;
(
  input  logic       req_if,
  input  logic       req_dm,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      if (req_if && req_dm) begin
        if (last_grant == REQ_DM) grant = 2'b01;
        else                      grant = 2'b10;
      end else if (req_if) begin
        grant = 2'b01;
      end else if (req_dm) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_32.sv
// Shares one single-ported memory between instruction fetch and load/store,
// one transaction at a time, with round-robin on simultaneous requests.
module mem_arbiter_32
  import mem_arbiter_32_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [WORD_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [WORD_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [WORD_W-1:0]   dm_addr,
  input  logic [WORD_W-1:0]   dm_wdata,
  output logic                dm_ack,
  output logic [WORD_W-1:0]   dm_rdata,
  output logic                dm_err,
  output logic [WORD_W-1:0]   mem_address,
  output logic [WORD_W-1:0]   mem_data,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  localparam int unsigned       CNT_W    = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t              state;
  logic                owner;
  logic                we_l;
  logic                last_grant;
  logic [WORD_W-1:0]   addr_l;
  logic [WORD_W-1:0]   wdata_l;
  logic [WORD_W-1:0]   rdata_r;
  logic                err_r;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          grant;
  logic                arb_en;
  logic                in_access;
  logic                in_done;

  assign arb_en = (state == IDLE);

  rr_arbiter_2 u_rr (
    .req_if     (if_req),
    .req_dm     (dm_req),
    .enable     (arb_en),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= REQ_IF;
      we_l       <= 1'b0;
      last_grant <= REQ_DM;
      addr_l     <= '0;
      wdata_l    <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            cnt        <= CNT_LOAD;
            state      <= ACCESS;
            if (grant[1]) begin
              addr_l  <= dm_addr;
              wdata_l <= dm_wdata;
              we_l    <= dm_we;
            end else begin
              addr_l  <= if_addr;
              wdata_l <= '0;
              we_l    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            rdata_r <= we_l ? '0 : mem_rdata;
            err_r   <= mem_err;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only state and latched values, never live inputs.
  assign in_access   = (state == ACCESS);
  assign in_done     = (state == DONE);
  assign mem_read    = in_access & ~we_l;
  assign mem_write   = in_access & we_l;
  assign mem_address = addr_l;
  assign mem_data    = wdata_l;

  assign if_ack   = in_done & (owner == REQ_IF);
  assign dm_ack   = in_done & (owner == REQ_DM);
  assign if_rdata = if_ack ? rdata_r : '0;
  assign if_err   = if_ack & err_r;
  assign dm_rdata = dm_ack ? rdata_r : '0;
  assign dm_err   = dm_ack & err_r;

endmodule

// File: doc/mem_arbiter_32.md
# mem_arbiter_32

Two-requester arbiter that shares the single-ported `memory` block between instruction fetch and the load/store path of `mips_cpu`. It runs one transaction at a time. Round-robin applies when both requesters ask in the same cycle. The arbiter owns the memory strobes for the configured read latency and returns the data and error to the winning requester with a one-cycle acknowledge pulse.

## Interface
- `LATENCY`, default 1: memory cycles a transaction occupies before data and error are sampled; legal range ≥1.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_addr` in 32: fetch byte address.
- `if_ack` out 1: one-cycle completion pulse.
- `if_rdata` out 32: fetch data, valid while `if_ack`.
- `if_err` out 1: invalid address, valid while `if_ack`.
- `dm_req` in 1: data request; held until `dm_ack`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: store data.
- `dm_ack` out 1: one-cycle completion pulse.
- `dm_rdata` out 32: load data, valid while `dm_ack`; 0 for stores.
- `dm_err` out 1: invalid address, valid while `dm_ack`.
- `mem_address` out 32: to `memory.input_address`.
- `mem_data` out 32: to `memory.input_data`.
- `mem_read` out 1: to `memory.read_enabled`.
- `mem_write` out 1: to `memory.write_enabled`.
- `mem_rdata` in 32: from `memory.output_data`.
- `mem_err` in 1: from `memory.err_invalid_address`.

## Operation
- FSM states:
  - IDLE: arbitrate. With any request pending, latch the owner, address, wdata and we, load `cnt` = LATENCY-1, and go to ACCESS. With no request, stay in IDLE.
  - ACCESS: `mem_read` = !we and `mem_write` = we, both for the owner. Address and data come from the latches. When `cnt`==0, register `mem_rdata` (or 0 for a store) and `mem_err`, then go to DONE. Otherwise decrement `cnt`.
  - DONE: pulse the owner's ack with the registered data and error. Memory strobes are low. Return to IDLE; no arbitration happens in DONE.
- Arbitration:
  - With a single request, that requester wins.
  - When both request, the requester other than `last_grant` wins.
  - `last_grant` updates on every grant.
  - The reset value of `last_grant` is DM, so fetch wins the first tie.
- Requester contract: hold req, addr, wdata and we stable until the ack cycle, and drop or re-raise req after it. Inputs are sampled only in IDLE, so changes during ACCESS or DONE have no effect.
- The non-owner's ack, rdata and err are 0.
- Reset, including in the middle of a transaction:
  - state = IDLE, `last_grant` = DM, `cnt` = 0.
  - All acks, errs, rdata, mem strobes, `mem_address` and `mem_data` = 0.
  - No ack is issued for an aborted transaction.

## Timing
- Request seen in IDLE in cycle 0 → strobes high in cycles 1..LATENCY → ack in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Minimum spacing between grants is LATENCY+2 cycles.
- A requester that re-raises req in the cycle after its ack competes normally. Under a continuous conflict, requests alternate IF, DM, IF, …
- All outputs are registered or decoded from state and latches. There is no combinational path from any input to any output.
- `cnt` width is $clog2(LATENCY) with a minimum of 1.

## Structure
- Shared package holds:
  - State encoding: IDLE, ACCESS, DONE.
  - Requester IDs: REQ_IF = 0, REQ_DM = 1.
  - Word width constant: 32.
- One sub-module is natural: `rr_arbiter_2`. It takes two requests, an enable, and `last_grant` state, and returns a one-hot grant.

## Test plan
- LATENCY=1, fetch only, `if_addr`=0x10, `mem_rdata`=0xDEADBEEF → `mem_read`=1 in cycle 1, `if_ack`=1 with `if_rdata`=0xDEADBEEF in cycle 2, `dm_ack`=0 throughout.
- Store, `dm_addr`=0x40, `dm_wdata`=0x12345678 → `mem_write`=1 and `mem_data`=0x12345678 in cycle 1, `mem_read`=0, `dm_ack`=1 with `dm_rdata`=0 in cycle 2.
- Both requesting from reset, held continuously, LATENCY=1 → grants IF, DM, IF, DM, with acks in cycles 2, 5, 8, 11.
- LATENCY=3, load with `mem_err`=1 → strobes high in cycles 1–3, `dm_ack`=1 and `dm_err`=1 in cycle 4.
- Reset asserted in cycle 2 of a LATENCY=3 fetch → strobes drop immediately, no `if_ack`. After release, a pending fetch restarts from IDLE.
- `dm_addr` changed during ACCESS → `mem_address` keeps its latched value.
